// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: PC register, instruction-memory addressing and the F/D pipeline register.
// Misaligned or out-of-range fetches become bubbles. The PC keeps following npc.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] npc,
  input  logic [31:0] F_instr,
  output logic [31:0] F_PC,
  output logic [11:0] im_addr,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic [31:0] D_offset,
  output logic [25:0] D_imm26,
  output logic        F_fault,
  output logic [31:0] fetch_cnt
);

  // Highest legal word address. It is kept at 33 bits so that a memory ending at 4 GiB cannot wrap.
  localparam logic [32:0] IM_LAST = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4) - 33'd4;

  logic [31:0] f_pc_q,      f_pc_d;
  logic [31:0] d_pc_q,      d_pc_d;
  logic [31:0] d_instr_q,   d_instr_d;
  logic        d_valid_q,   d_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic fault_misaligned;
  logic fault_below;
  logic fault_above;
  logic f_fault;

  always_comb begin
    fault_misaligned = (f_pc_q[1:0] != 2'b00);
    fault_below      = (f_pc_q < IM_BASE);
    fault_above      = ({1'b0, f_pc_q} > IM_LAST);
    f_fault          = fault_misaligned | fault_below | fault_above;
  end

  always_comb begin
    f_pc_d      = f_pc_q;
    d_pc_d      = d_pc_q;
    d_instr_d   = d_instr_q;
    d_valid_d   = d_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    if (!stall) begin
      // A flush that arrives together with a stall is dropped on purpose and is not remembered.
      f_pc_d = npc;
      d_pc_d = f_pc_q;
      if (flush) begin
        d_instr_d = 32'h0000_0000;
        d_valid_d = 1'b0;
      end else begin
        d_instr_d = f_fault ? 32'h0000_0000 : F_instr;
        d_valid_d = ~f_fault;
        if (!f_fault) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc_q      <= PC_RESET;
      d_pc_q      <= PC_RESET;
      d_instr_q   <= 32'h0000_0000;
      d_valid_q   <= 1'b0;
      fetch_cnt_q <= 32'h0000_0000;
    end else begin
      f_pc_q      <= f_pc_d;
      d_pc_q      <= d_pc_d;
      d_instr_q   <= d_instr_d;
      d_valid_q   <= d_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign F_PC      = f_pc_q;
  assign im_addr   = 12'((f_pc_q - IM_BASE) >> 2);
  assign F_fault   = f_fault;
  assign D_PC      = d_pc_q;
  assign D_instr   = d_instr_q;
  assign D_valid   = d_valid_q;
  assign D_offset  = {{16{d_instr_q[15]}}, d_instr_q[15:0]};
  assign D_imm26   = d_instr_q[25:0];
  assign fetch_cnt = fetch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: scoreboard bench driven by directed and random stimulus.
// Each clock edge is checked against a behavioural model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] PC_RST = 32'h0000_3000;
  localparam logic [31:0] BASE   = 32'h0000_3000;
  localparam int          WORDS  = 4096;
  localparam logic [31:0] LAST   = BASE + 32'(4 * WORDS) - 32'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] npc = 32'h0;
  logic [31:0] f_instr, f_pc, d_pc, d_instr, d_offset, fetch_cnt;
  logic [11:0] im_addr;
  logic [25:0] d_imm26;
  logic        d_valid, f_fault;

  logic [31:0] im_mem [WORDS];

  fetch_unit #(.PC_RESET(PC_RST), .IM_BASE(BASE), .IM_WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .npc(npc),
    .F_instr(f_instr), .F_PC(f_pc), .im_addr(im_addr), .D_PC(d_pc),
    .D_instr(d_instr), .D_valid(d_valid), .D_offset(d_offset),
    .D_imm26(d_imm26), .F_fault(f_fault), .fetch_cnt(fetch_cnt)
  );

  // The instruction memory is environment, not a source of expected values.
  assign f_instr = im_mem[im_addr];

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dpc;
    logic [31:0] dinstr;
    logic [31:0] cnt;
    logic        dvalid;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc, m_dpc, m_dinstr, m_cnt;
  logic        m_dvalid;

  function automatic logic is_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (longint'(pc) < longint'(BASE)) ||
           (longint'(pc) > longint'(BASE) + 4 * WORDS - 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input exp_t e);
    chk("F_PC", f_pc, e.pc);
    chk("D_PC", d_pc, e.dpc);
    chk("D_instr", d_instr, e.dinstr);
    chk("D_valid", {31'b0, d_valid}, {31'b0, e.dvalid});
    chk("fetch_cnt", fetch_cnt, e.cnt);
    chk("F_fault", {31'b0, f_fault}, {31'b0, is_fault(e.pc)});
    chk("im_addr", {20'b0, im_addr}, {20'b0, 12'((e.pc - BASE) / 4)});
    chk("D_offset", d_offset, 32'($signed(e.dinstr[15:0])));
    chk("D_imm26", {6'b0, d_imm26}, {6'b0, e.dinstr[25:0]});
  endtask

  task automatic model_reset();
    m_pc = PC_RST; m_dpc = PC_RST; m_dinstr = 32'h0; m_dvalid = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic [31:0] n);
    logic flt;
    if (st) return;
    flt = is_fault(m_pc);
    m_dpc = m_pc;
    if (fl || flt) begin
      m_dinstr = 32'h0;
      m_dvalid = 1'b0;
    end else begin
      m_dinstr = im_mem[(m_pc - BASE) / 4];
      m_dvalid = 1'b1;
      m_cnt    = m_cnt + 32'd1;
    end
    m_pc = n;
  endtask

  task automatic check_reset_values(input string tag);
    exp_t e;
    e = '{PC_RST, PC_RST, 32'h0, 32'h0, 1'b0};
    check_state(e);
    chk({tag, "_D_offset_zero"}, d_offset, 32'h0);
  endtask

  // Called at posedge+2. It drives the inputs, predicts the state after the next edge and queues the prediction.
  task automatic cycle(input logic st, input logic fl, input logic [31:0] n);
    stall = st; flush = fl; npc = n;
    model_step(st, fl, n);
    exp_q.push_back('{m_pc, m_dpc, m_dinstr, m_cnt, m_dvalid});
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_state(e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [31:0] n;
    for (int i = 0; i < WORDS; i++) im_mem[i] = $urandom;
    im_mem[0] = 32'hA5A5_8001;
    im_mem[1] = 32'h0BBB_7FFF;
    im_mem[2] = 32'hCCCC_C00C;
    model_reset();

    repeat (2) @(posedge clk);
    #2;
    check_reset_values("reset");
    reset = 1'b0;

    // Sequential fetch of A, B, C, then a stall held on 3008, then resume.
    cycle(0, 0, m_pc + 4);
    cycle(0, 0, m_pc + 4);
    cycle(1, 0, 32'h0000_4444);
    cycle(1, 0, 32'h0000_5554);
    cycle(0, 0, m_pc + 4);
    // A flush alone, and then a flush together with a stall.
    cycle(0, 1, m_pc + 4);
    cycle(1, 1, m_pc + 4);
    cycle(0, 0, m_pc + 4);
    // The last legal word, then out-of-range and misaligned fetches.
    cycle(0, 0, LAST);
    cycle(0, 0, 32'h0000_7000);
    cycle(0, 0, 32'h0000_3002);
    cycle(0, 0, 32'h0000_2FFC);
    cycle(0, 0, 32'h0000_3010);
    cycle(0, 0, 32'h0000_3014);

    // Asynchronous reset while stalled on 3010.
    cycle(0, 0, 32'h0000_3010);
    cycle(1, 0, 32'h0000_3014);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(posedge clk);
    #2;
    check_reset_values("reset_held");
    stall = 1'b0;
    reset = 1'b0;

    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      n = m_pc + 4;
      else if (r < 80) n = BASE + 4 * $urandom_range(0, WORDS - 1);
      else if (r < 88) n = BASE + 32'($urandom_range(0, 4 * WORDS - 1)) | 32'h1;
      else if (r < 94) n = LAST + 4 + 4 * $urandom_range(0, 15);
      else             n = BASE - 4 * $urandom_range(1, 16);
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, n);
    end

    // Counter wrap: fetch_cnt is preloaded to all ones before a single valid load.
    cycle(0, 0, BASE + 32'h20);
    cycle(0, 0, BASE + 32'h24);
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    cycle(0, 0, BASE + 32'h28);
    cycle(0, 0, BASE + 32'h2C);

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000: F_PC value after reset.
REQ-002 Parameter IM_BASE, default 32'h0000_3000: byte address of instruction-memory word 0.
REQ-003 Parameter IM_WORDS, default 4096: instruction-memory depth in words; IM address width is 12.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 stall  input  1  hazard stall from D-stage hazard logic; holds the PC and the F/D register.
REQ-007 flush  input  1  loads a bubble into the F/D register.
REQ-008 npc  input  32  next-PC from the next-PC unit; loaded into the PC when not stalled.
REQ-009 F_instr  input  32  instruction word read combinationally from IM at im_addr.
REQ-010 F_PC  output  32  current fetch PC; also drives the next-PC unit's F_PC.
REQ-011 im_addr  output  12  IM word index, (F_PC - IM_BASE) >> 2, truncated to 12 bits.
REQ-012 D_PC  output  32  PC of the instruction held in D.
REQ-013 D_instr  output  32  instruction held in D.
REQ-014 D_valid  output  1  D holds a real, in-range fetch and not a bubble.
REQ-015 D_offset  output  32  sign-extended D_instr[15:0], for the next-PC unit's offset.
REQ-016 D_imm26  output  26  D_instr[25:0], for the next-PC unit's imm26.
REQ-017 F_fault  output  1  combinational; F_PC is misaligned or outside [IM_BASE, IM_BASE+4*IM_WORDS-4].
REQ-018 fetch_cnt  output  32  count of valid instructions loaded into D.

Function
REQ-019 PC register: on a clock edge with reset low and stall low, F_PC SHALL load npc; with stall high, F_PC SHALL hold.
REQ-020 F/D register, priority per edge (reset > stall > flush > load):
- stall=1: D_PC, D_instr, D_valid and fetch_cnt hold, even when flush=1.
- stall=0 and flush=1: D_instr=0 (nop), D_valid=0, D_PC=F_PC.
- otherwise: D_PC=F_PC, D_instr = F_fault ? 0 : F_instr, D_valid = !F_fault.
REQ-021 stall=1 together with flush=1 SHALL be treated as stall; the flush is dropped and is not remembered.
REQ-022 fetch_cnt SHALL increment by 1 on each edge that loads D_valid=1, and wrap from 32'hFFFF_FFFF to 0.
REQ-023 Latency: an instruction at F_PC in cycle n SHALL appear on D_instr in cycle n+1 when not stalled.
REQ-024 D_offset and D_imm26 SHALL be combinational functions of the registered D_instr only.
REQ-025 F_fault SHALL be 1 when F_PC[1:0]!=0, F_PC<IM_BASE, or F_PC>IM_BASE+4*IM_WORDS-4.
REQ-026 A faulted fetch SHALL NOT stop the PC, which keeps loading npc; the unit does not raise exceptions.
REQ-027 im_addr SHALL always be driven, including during a fault; IM contents are ignored on a fault.
REQ-028 The branch delay slot is architectural: flush is never asserted for taken branches, only by external control.

Reset
REQ-029 While reset=1: F_PC=PC_RESET, D_PC=PC_RESET, D_instr=0, D_valid=0, fetch_cnt=0.
REQ-030 Reset SHALL act immediately without a clock edge, including when asserted mid-stall.
REQ-031 The first edge after reset deasserts SHALL load D with the instruction at PC_RESET and set F_PC=npc.
REQ-032 Outputs during reset: D_offset=0, D_imm26=0, im_addr=0, F_fault=0.

Verification
REQ-033 Reset, then npc=F_PC+4 for 3 cycles with IM[0..2]=A,B,C:
- F_PC = 3000, 3004, 3008, 300C;
- D_instr = A, B, C;
- fetch_cnt = 3.
REQ-034 Stall held for 2 cycles with F_PC=3008: F_PC, D_PC and D_instr unchanged and fetch_cnt unchanged; fetch resumes at npc on the first unstalled edge.
REQ-035 Flush=1 for 1 cycle: D_instr=0, D_valid=0, D_PC=F_PC of that cycle, fetch_cnt not incremented. With stall=1 and flush=1 together: D holds its previous values.
REQ-036 npc=32'h0000_7000, then npc=32'h0000_3002: F_fault=1 in both cycles; D_instr=0 and D_valid=0 on the following edge; F_PC still loads npc.
REQ-037 Reset asserted asynchronously between edges while F_PC=3010 and stall=1: outputs take the REQ-029 values before the next clock edge.
REQ-038 Preload fetch_cnt to 32'hFFFF_FFFF via a bench force, then do one valid load: fetch_cnt=0.
